// File: rtl/seg7_scan_display_pkg.sv
// Shared 7-segment encodings ({a..g}, active low) for the scan driver and the
// single-digit decode logic elsewhere on the board.
package seg7_scan_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_display_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit 7-segment driver: shadow-latched value, per-digit dp/blink,
// leading-zero suppression and an all-anodes-off guard at the start of each slot.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
)(
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0][3:0] data_q;
  logic [DIGITS-1:0]      dp_q, blink_q;
  logic [CW-1:0]          scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]          dig_idx_q, dig_idx_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_ph_q, blink_ph_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_out_q, dp_out_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   frame_q;

  logic                   slot_end, last_dig, frame_wrap;
  logic                   guard, blank, lz_run;
  logic [DIGITS-1:0]      lz_blank;
  logic [6:0]             dec_seg;

  seg7_hex_decoder u_dec (.hex_i(data_q[dig_idx_q]), .seg_o(dec_seg));

  if (GUARD > 0) begin : g_guard
    assign guard = (scan_cnt_q < CW'(GUARD));
  end else begin : g_noguard
    assign guard = 1'b0;
  end

  // A digit goes dark only while every digit above it is also a zero without dp.
  always_comb begin
    lz_blank = '0;
    lz_run   = lz_en;
    for (int d = DIGITS - 1; d > 0; d--) begin
      lz_run      = lz_run & (data_q[d] == 4'h0) & ~dp_q[d];
      lz_blank[d] = lz_run;
    end
  end

  always_comb begin
    slot_end    = (scan_cnt_q == CW'(SCAN_DIV - 1));
    last_dig    = (dig_idx_q == IW'(DIGITS - 1));
    frame_wrap  = slot_end & last_dig;
    scan_cnt_d  = slot_end ? '0 : scan_cnt_q + 1'b1;
    dig_idx_d   = dig_idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (slot_end) dig_idx_d = last_dig ? '0 : dig_idx_q + 1'b1;
    if (frame_wrap) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    // Blinked-off digits keep their anode driven; only segments go dark.
    blank    = guard | (blink_q[dig_idx_q] & blink_ph_q) | lz_blank[dig_idx_q];
    seg_d    = blank ? SEG_BLANK : dec_seg;
    dp_out_d = blank | ~dp_q[dig_idx_q];
    an_d     = guard ? '1 : ~(DIGITS'(1) << dig_idx_q);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      data_q      <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_out_q    <= 1'b1;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= data_in;
        dp_q    <= dp_in;
        blink_q <= blink_in;
      end
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      an_q        <= an_d;
      frame_q     <= frame_wrap;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_out_q;
  assign an_out      = an_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2,
// one instance with GUARD=1 and one with GUARD=0.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n, load, lz_en;
  logic [15:0] data;
  logic [3:0]  dp, blink;
  logic [6:0]  seg, seg_g0;
  logic        dpo, dpo_g0, fs, fs_g0;
  logic [3:0]  an, an_g0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .load(load), .data_in(data), .dp_in(dp),
    .blink_in(blink), .lz_en(lz_en), .seg_out(seg), .dp_out(dpo), .an_out(an),
    .frame_start(fs));

  seg7_scan_display #(.DIGITS(4), .SCAN_DIV(4), .GUARD(0), .BLINK_FRAMES(2)) u_g0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .load(load), .data_in(data), .dp_in(dp),
    .blink_in(blink), .lz_en(lz_en), .seg_out(seg_g0), .dp_out(dpo_g0), .an_out(an_g0),
    .frame_start(fs_g0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_vals(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blink = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Returns just after the edge where frame_start is seen high.
  task automatic sync_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (fs) seen = 1;
    end
    chk({tag, "_sync"}, 32'(seen), 32'd1);
  endtask

  // Checks the 16 output cycles of one frame; assumes sync on entry, stays synced on exit.
  task automatic check_frame(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp);
    for (int j = 1; j <= 16; j++) begin
      int         slot;
      bit         g;
      logic [3:0] ea;
      logic [6:0] eseg;
      logic       ed;
      step();
      slot = (j - 1) / 4;
      g    = ((j - 1) % 4) == 0;
      ea   = g ? 4'hF : ~(4'b0001 << slot);
      eseg = g ? 7'h7F : es[slot];
      ed   = g ? 1'b1 : edp[slot];
      chk($sformatf("%s_an%0d", tag, j), 32'(an), 32'(ea));
      chk($sformatf("%s_seg%0d", tag, j), 32'(seg), 32'(eseg));
      chk($sformatf("%s_dp%0d", tag, j), 32'(dpo), 32'(ed));
      chk($sformatf("%s_fs%0d", tag, j), 32'(fs), 32'(j == 16));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; lz_en = 1'b0; data = '0; dp = '0; blink = '0;
    repeat (2) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp",  32'(dpo), 32'd1);
    chk("rst_an",  32'(an),  32'hF);
    chk("rst_fs",  32'(fs),  32'd0);
    chk("rst_an_g0", 32'(an_g0), 32'hF);

    // 1: plain value, digits 0..3 = 4,3,2,1
    rst_n = 1'b1;
    load_vals(16'h1234, 4'h0, 4'h0);
    sync_frame("t1");
    check_frame("t1", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF);

    // 2: leading zeros suppressed, then shown
    lz_en = 1'b1;
    load_vals(16'h00A0, 4'h0, 4'h0);
    sync_frame("t2a");
    check_frame("t2a", {7'h7F, 7'h7F, 7'b0001000, 7'b0000001}, 4'hF);
    lz_en = 1'b0;
    sync_frame("t2b");
    check_frame("t2b", {7'b0000001, 7'b0000001, 7'b0001000, 7'b0000001}, 4'hF);

    // 3: zero value with dp on digit 2 stops suppression at digit 2
    lz_en = 1'b1;
    load_vals(16'h0000, 4'b0100, 4'h0);
    sync_frame("t3");
    check_frame("t3", {7'h7F, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1011);

    // 5: load mid-slot switches the whole value atomically, 2-cycle latency
    lz_en = 1'b0;
    load_vals(16'h1234, 4'h0, 4'h0);
    sync_frame("t5");
    step();
    step();
    chk("t5_pre", 32'(seg), 32'(7'b1001100));
    data = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    chk("t5_loadedge", 32'(seg), 32'(7'b1001100));
    step();
    chk("t5_new", 32'(seg), 32'(7'b0000000));
    sync_frame("t5b");
    check_frame("t5b", {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'hF);

    // 4: blink digit 0, phase starts at 0 after reset: frames 1 lit, 2-3 dark, 4 lit
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    load_vals(16'h1234, 4'h0, 4'b0001);
    sync_frame("t4");
    check_frame("t4f1", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF);
    check_frame("t4f2", {7'b1001111, 7'b0010010, 7'b0000110, 7'h7F}, 4'hF);
    check_frame("t4f3", {7'b1001111, 7'b0010010, 7'b0000110, 7'h7F}, 4'hF);
    check_frame("t4f4", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF);

    // 6: one-cycle reset mid-scan; scan restarts at digit 0 with cleared shadow
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_seg", 32'(seg), 32'h7F);
    chk("t6_dp",  32'(dpo), 32'd1);
    chk("t6_an",  32'(an),  32'hF);
    chk("t6_fs",  32'(fs),  32'd0);
    chk("t6_an_g0", 32'(an_g0), 32'hF);
    for (int j = 1; j <= 8; j++) begin
      int         slot;
      bit         g;
      logic [3:0] ea, ea0;
      logic [6:0] eseg;
      step();
      slot = (j - 1) / 4;
      g    = ((j - 1) % 4) == 0;
      ea0  = ~(4'b0001 << slot);
      ea   = g ? 4'hF : ea0;
      eseg = g ? 7'h7F : 7'b0000001;
      chk($sformatf("t6_an%0d", j), 32'(an), 32'(ea));
      chk($sformatf("t6_seg%0d", j), 32'(seg), 32'(eseg));
      chk($sformatf("t6_fs%0d", j), 32'(fs), 32'd0);
      chk($sformatf("t6_g0_an%0d", j), 32'(an_g0), 32'(ea0));
      chk($sformatf("t6_g0_seg%0d", j), 32'(seg_g0), 32'(7'b0000001));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
